// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key schedule and the cipher datapath:
// word type, round-constant seed and the RotWord / xtime helpers.
package aes_pkg;

   typedef logic [31:0] aes_word_t;

   localparam logic [7:0] RCON_INIT  = 8'h01;
   localparam logic [7:0] XTIME_POLY = 8'h1b;

   // Byte 0 is the most significant byte: [a0 a1 a2 a3] -> [a1 a2 a3 a0]
   function automatic aes_word_t rotword(input aes_word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte in, one byte out, purely combinational lookup.
module aes_sbox (
   input  logic [7:0] byte_i,
   output logic [7:0] byte_o
);

   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign byte_o = SBOX[{byte_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES key schedule: one 32-bit schedule word per clock into key_e.
// Define AES_KEYEXP_ZEROIZE_EN to add a zeroize input that wipes the schedule.
//
//   state     | meaning
//   ST_IDLE   | waiting for start; key_e holds the last schedule
//   ST_EXPAND | computing w[i], one word per clock
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int nk = 4,
   parameter int nr = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
`ifdef AES_KEYEXP_ZEROIZE_EN
   input  logic                    zeroize,
`endif
   input  logic [0:32*nk-1]        key_in,
   output logic                    busy,
   output logic                    done,
   output logic                    key_valid,
   output logic [0:128*(nr+1)-1]   key_e
);

   localparam int NW = 4 * (nr + 1);
   localparam int KW = 32 * NW;
   localparam int IW = $clog2(NW);

   if (!((nk == 4 || nk == 6 || nk == 8) && nr == nk + 6)) begin : g_param_chk
      $error("aes_key_expand: nk must be 4, 6 or 8 and nr must equal nk+6");
   end

   typedef enum logic {ST_IDLE, ST_EXPAND} state_t;

   state_t          state_q, state_d;
   logic [0:KW-1]   key_q, key_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [2:0]      mod_q, mod_d;
   logic [7:0]      rcon_q, rcon_d;
   logic            done_q, done_d;
   logic            valid_q, valid_d;

   logic [IW-1:0]   prev_idx, back_idx;
   aes_word_t       prev_w, back_w, sbox_in, sbox_out, temp_w;

   assign prev_idx = idx_q - IW'(1);
   assign back_idx = idx_q - IW'(nk);
   assign prev_w   = key_q[{prev_idx, 5'b00000} +: 32];
   assign back_w   = key_q[{back_idx, 5'b00000} +: 32];
   assign sbox_in  = (mod_q == 3'd0) ? rotword(prev_w) : prev_w;

   // Four shared S-boxes serve both the RotWord and the AES-256 mid-key SubWord paths
   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .byte_i (sbox_in[8*b +: 8]),
         .byte_o (sbox_out[8*b +: 8])
      );
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      mod_d   = mod_q;
      rcon_d  = rcon_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      temp_w  = prev_w;

      if (mod_q == 3'd0) begin
         temp_w = sbox_out ^ {rcon_q, 24'h000000};
      end else if (nk == 8 && mod_q == 3'd4) begin
         temp_w = sbox_out;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               key_d             = '0;
               key_d[0 +: 32*nk] = key_in;
               valid_d           = 1'b0;
               idx_d             = IW'(nk);
               mod_d             = '0;
               rcon_d            = RCON_INIT;
               state_d           = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            key_d[{idx_q, 5'b00000} +: 32] = back_w ^ temp_w;
            idx_d = idx_q + IW'(1);
            mod_d = (mod_q == 3'(nk - 1)) ? 3'd0 : mod_q + 3'd1;
            if (mod_q == 3'd0) begin
               rcon_d = xtime(rcon_q);
            end
            if (idx_q == IW'(NW - 1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef AES_KEYEXP_ZEROIZE_EN
      if (zeroize) begin
         state_d = ST_IDLE;
         key_d   = '0;
         idx_d   = '0;
         mod_d   = '0;
         rcon_d  = RCON_INIT;
         valid_d = 1'b0;
         done_d  = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         idx_q   <= '0;
         mod_q   <= '0;
         rcon_q  <= RCON_INIT;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
         mod_q   <= mod_d;
         rcon_q  <= rcon_d;
         done_q  <= done_d;
         valid_q <= valid_d;
      end
   end

   assign busy      = (state_q == ST_EXPAND);
   assign done      = done_q;
   assign key_valid = valid_q;
   assign key_e     = key_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: AES-128 and AES-256 instances checked
// against FIPS-197 key-expansion vectors, with ignored-start, reset and zeroize runs.
module tb_aes_key_expand;

   localparam int N4 = 40;
   localparam int N8 = 52;
   localparam logic [0:127] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [0:255] KEY256 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start4 = 1'b0, start8 = 1'b0;
   logic [0:127]   key4 = '0;
   logic [0:255]   key8 = '0;
   logic           busy4, done4, valid4, busy8, done8, valid8;
   logic [0:1407]  e4;
   logic [0:1919]  e8;
`ifdef AES_KEYEXP_ZEROIZE_EN
   logic           zeroize = 1'b0;
`endif

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int           exp_cyc;
      logic [127:0] rk0;
      logic [31:0]  w;
      int           wi;
      logic [127:0] rk;
      int           ri;
   } exp_t;

   exp_t q4[$];
   exp_t q8[$];

   aes_key_expand #(.nk(4), .nr(10)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start4),
`ifdef AES_KEYEXP_ZEROIZE_EN
      .zeroize   (zeroize),
`endif
      .key_in    (key4),
      .busy      (busy4),
      .done      (done4),
      .key_valid (valid4),
      .key_e     (e4)
   );

   aes_key_expand #(.nk(8), .nr(14)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start8),
`ifdef AES_KEYEXP_ZEROIZE_EN
      .zeroize   (1'b0),
`endif
      .key_in    (key8),
      .busy      (busy8),
      .done      (done8),
      .key_valid (valid8),
      .key_e     (e8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Called at a negedge; the following posedge samples start.
   task automatic start_run4();
      exp_t ex;
      key4 = KEY128;
      start4 = 1'b1;
      ex.exp_cyc = cyc + 1 + N4;
      ex.rk0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      ex.w   = 32'ha0fafe17;
      ex.wi  = 4;
      ex.rk  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      ex.ri  = 10;
      q4.push_back(ex);
      @(negedge clk);
      start4 = 1'b0;
   endtask

   task automatic start_run8();
      exp_t ex;
      key8 = KEY256;
      start8 = 1'b1;
      ex.exp_cyc = cyc + 1 + N8;
      ex.rk0 = 128'h603deb1015ca71be2b73aef0857d7781;
      ex.w   = 32'h9ba35411;
      ex.wi  = 8;
      ex.rk  = 128'hfe4890d1e6188d0b046df344706c631e;
      ex.ri  = 14;
      q8.push_back(ex);
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic wait_q4();
      int k = 0;
      while (q4.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      check("q4_drain_timeout", 128'(q4.size()), 128'd0);
   endtask

   task automatic wait_q8();
      int k = 0;
      while (q8.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      check("q8_drain_timeout", 128'(q8.size()), 128'd0);
   endtask

   always @(negedge clk) begin
      if (done4) begin
         if (q4.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done4_unexpected: got done=1, required 0 (cycle %0d)", cyc);
         end else begin
            exp_t ex;
            ex = q4.pop_front();
            check("lat128", 128'(cyc), 128'(ex.exp_cyc));
            check("rk0_128", e4[0 +: 128], ex.rk0);
            check("w4_128", 128'(e4[32*ex.wi +: 32]), 128'(ex.w));
            check("rk10_128", e4[128*ex.ri +: 128], ex.rk);
            check("valid_at_done128", 128'(valid4), 128'd1);
            check("busy_at_done128", 128'(busy4), 128'd0);
         end
      end
   end

   always @(negedge clk) begin
      if (done8) begin
         if (q8.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done8_unexpected: got done=1, required 0 (cycle %0d)", cyc);
         end else begin
            exp_t ex;
            ex = q8.pop_front();
            check("lat256", 128'(cyc), 128'(ex.exp_cyc));
            check("rk0_256", e8[0 +: 128], ex.rk0);
            check("w8_256", 128'(e8[32*ex.wi +: 32]), 128'(ex.w));
            check("rk14_256", e8[128*ex.ri +: 128], ex.rk);
            check("valid_at_done256", 128'(valid8), 128'd1);
            check("busy_at_done256", 128'(busy8), 128'd0);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_key_e", 128'(|e4), 128'd0);
      check("rst_valid", 128'(valid4), 128'd0);
      check("rst_busy", 128'(busy4), 128'd0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("idle_busy", 128'(busy4), 128'd0);
      check("idle_valid", 128'(valid4), 128'd0);
      check("idle_key_e", 128'(|e4), 128'd0);

      // AES-128 run with a stray start at edge 10 that must be ignored
      start_run4();
      check("start_busy", 128'(busy4), 128'd1);
      check("start_valid", 128'(valid4), 128'd0);
      repeat (9) @(negedge clk);
      key4 = ~KEY128;
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      key4 = '0;
      check("busy_mid_run", 128'(busy4), 128'd1);
      wait_q4();
      repeat (4) @(negedge clk);
      check("hold_valid", 128'(valid4), 128'd1);
      check("hold_busy", 128'(busy4), 128'd0);
      check("hold_rk10", e4[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Reset at edge 20 aborts the run; a full rerun must still be correct
      start_run4();
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 128'(busy4), 128'd0);
      check("abort_valid", 128'(valid4), 128'd0);
      check("abort_done", 128'(done4), 128'd0);
      check("abort_key_e", 128'(|e4), 128'd0);
      q4.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_run4();
      wait_q4();

      // AES-256
      start_run8();
      check("start_busy256", 128'(busy8), 128'd1);
      wait_q8();

`ifdef AES_KEYEXP_ZEROIZE_EN
      start_run4();
      repeat (14) @(negedge clk);
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      check("zero_busy", 128'(busy4), 128'd0);
      check("zero_valid", 128'(valid4), 128'd0);
      check("zero_key_e", 128'(|e4), 128'd0);
      q4.delete();
      zeroize = 1'b1;
      key4 = KEY128;
      start4 = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      start4 = 1'b0;
      check("zero_start_rejected", 128'(busy4), 128'd0);
      repeat (60) @(negedge clk);
      check("zero_stays_clear", 128'(valid4), 128'd0);
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
